// File: rtl/rr_one_hot_arbiter.sv
// rr_one_hot_arbiter: round-robin arbiter that drives the one-hot select of a
// one_hot_mux. The registered grant is held until the downstream valid/ready
// handshake accepts it. If the winner withdraws its request first, the grant
// is revoked.
// Optional feature: define RR_ARB_BURST_EN to let a winner keep the grant for
// up to MAX_BURST consecutive accepts while it still requests.
module rr_one_hot_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  input  logic               grant_ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] ptr;       // highest-priority requester
  logic [PTR_W-1:0] win_idx;   // index of the bit set in grant
  logic [PTR_W-1:0] rot_ptr;   // pointer just past the current winner
  logic [PTR_W-1:0] srch_ptr;  // start point for this cycle's search
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             req_win;
  logic             accept;
  logic             revoke;

`ifdef RR_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  logic [CNT_W-1:0] burst_cnt;
  logic             burst_keep;
`endif

  assign grant_valid = |grant;
  assign req_win     = req[win_idx];
  assign accept      = (state == S_GRANT) & grant_ready;
  assign revoke      = (state == S_GRANT) & ~grant_ready & ~req_win;

  // Pointer past the winner, wrapping at NUM_REQ-1; used for re-arbitration on accept
  always_comb begin
    rot_ptr  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    srch_ptr = (state == S_GRANT) ? rot_ptr : ptr;
  end

  // Circular priority search starting at srch_ptr; scanning from the far end
  // lets the nearest requester overwrite the result last
  always_comb begin
    int idx;
    pick_any = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(srch_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[PTR_W'(idx)]) begin
        pick_any = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
  end

`ifdef RR_ARB_BURST_EN
  // Keep the same winner while it still requests and has burst budget left
  always_comb burst_keep = req_win && (burst_cnt < CNT_W'(MAX_BURST - 1));
`endif

  // Grant FSM: register the winner, hold until accept, rotate or revoke
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      grant   <= '0;
      win_idx <= '0;
      ptr     <= '0;
`ifdef RR_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef RR_ARB_BURST_EN
          burst_cnt <= '0;
`endif
          if (pick_any) begin
            grant   <= NUM_REQ'(1) << pick_idx;
            win_idx <= pick_idx;
            state   <= S_GRANT;
          end
        end
        default: begin
          if (accept) begin
`ifdef RR_ARB_BURST_EN
            if (burst_keep) begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
              burst_cnt <= '0;
`else
            begin
`endif
              ptr <= rot_ptr;
              if (pick_any) begin
                grant   <= NUM_REQ'(1) << pick_idx;
                win_idx <= pick_idx;
              end else begin
                grant <= '0;
                state <= S_IDLE;
              end
            end
          end else if (revoke) begin
            // Winner withdrew before acceptance: one-cycle bubble, ptr kept
            grant <= '0;
            state <= S_IDLE;
`ifdef RR_ARB_BURST_EN
            burst_cnt <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule
